// File: rtl/diff_sweep_engine_pkg.sv
// Shared constants and FSM state type for the YIN difference sweep engine.
// Default widths live here so later pipeline stages agree on them.
package diff_sweep_engine_pkg;

  localparam int DATA_WIDTH_BITS    = 16;
  localparam int BUFFER_SIZE_BITS   = 10;
  localparam int WINDOW_SIZE_BITS_D = 8;
  localparam int TAU_WIDTH_D        = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_A,
    ST_READ_B,
    ST_LAST,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/diff_sweep_engine_if.sv
// Control, sample-buffer read port and result stream of the sweep engine.
// master = engine side, slave = surrounding system (buffer, controller, consumer).
interface diff_sweep_engine_if #(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDRESS_WIDTH    = 10,
  parameter int WINDOW_SIZE_BITS = 8,
  parameter int TAU_WIDTH        = 9
);
  localparam int ACC_WIDTH = 2 * DATA_WIDTH + WINDOW_SIZE_BITS;

  logic                            start;
  logic [ADDRESS_WIDTH-1:0]        base_address;
  logic [TAU_WIDTH-1:0]            tau_min;
  logic [TAU_WIDTH-1:0]            tau_max;
  logic [ADDRESS_WIDTH-1:0]        address;
  logic                            mem_oe;
  logic signed [DATA_WIDTH-1:0]    data_in;
  logic                            out_valid;
  logic                            out_ready;
  logic [TAU_WIDTH-1:0]            out_tau;
  logic [ACC_WIDTH-1:0]            out_diff;
  logic                            busy;
  logic                            done;

  modport master (
    input  start, base_address, tau_min, tau_max, data_in, out_ready,
    output address, mem_oe, out_valid, out_tau, out_diff, busy, done
  );

  modport slave (
    output start, base_address, tau_min, tau_max, data_in, out_ready,
    input  address, mem_oe, out_valid, out_tau, out_diff, busy, done
  );

endinterface

// File: rtl/diff_sweep_engine_sq_diff_unit.sv
// Exact squared difference of two signed samples: (a-b)^2 as an unsigned value.
// Squaring the magnitude keeps the product at 2*DATA_WIDTH bits with no sign bits to discard.
module sq_diff_unit #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic [2*DATA_WIDTH-1:0]      sq
);

  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH-1:0]      mag;

  assign diff = (DATA_WIDTH+1)'(a) - (DATA_WIDTH+1)'(b);
  // |diff| <= 2^DATA_WIDTH - 1, so the magnitude always fits DATA_WIDTH bits
  assign mag  = diff[DATA_WIDTH] ? DATA_WIDTH'(-diff) : DATA_WIDTH'(diff);
  assign sq   = (2*DATA_WIDTH)'(mag) * (2*DATA_WIDTH)'(mag);

endmodule

// File: rtl/diff_sweep_engine.sv
// Sweeps tau over [tau_min, tau_max] computing the YIN difference d(tau) over a
// 2^WINDOW_SIZE_BITS window, reading two samples per step from a circular buffer.
module diff_sweep_engine
  import diff_sweep_engine_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_BITS,
  parameter int ADDRESS_WIDTH    = BUFFER_SIZE_BITS,
  parameter int WINDOW_SIZE_BITS = WINDOW_SIZE_BITS_D,
  parameter int TAU_WIDTH        = TAU_WIDTH_D
) (
  input  logic                clk,
  input  logic                reset,
  diff_sweep_engine_if.master bus
);

  localparam int ACC_WIDTH = 2 * DATA_WIDTH + WINDOW_SIZE_BITS;
  localparam int SUM_WIDTH = ADDRESS_WIDTH + TAU_WIDTH + WINDOW_SIZE_BITS;
  localparam logic [WINDOW_SIZE_BITS-1:0] J_LAST = '1;

  state_t                       state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0]     base_reg;
  logic [TAU_WIDTH-1:0]         tau_min_reg, tau_max_reg, tau_reg;
  logic [WINDOW_SIZE_BITS-1:0]  j_reg;
  logic [ACC_WIDTH-1:0]         acc_reg;
  logic signed [DATA_WIDTH-1:0] sample_a_reg;
  logic [ADDRESS_WIDTH-1:0]     address_reg;
  logic                         done_reg;

  logic [2*DATA_WIDTH-1:0]      sq;
  logic                         last_tau;
  logic                         handshake;
  logic [SUM_WIDTH-1:0]         addr_a_next, addr_b;

  sq_diff_unit #(.DATA_WIDTH(DATA_WIDTH)) u_sq (
    .a  (sample_a_reg),
    .b  (bus.data_in),
    .sq (sq)
  );

  // A reversed range degenerates to a single lag at tau_min
  assign last_tau  = (tau_reg == tau_max_reg) || (tau_max_reg < tau_min_reg);
  assign handshake = (state_reg == ST_EMIT) && bus.out_ready;

  // Wide sums, then truncation, give modulo-2^ADDRESS_WIDTH wrap with tau zero-extended
  assign addr_b      = SUM_WIDTH'(base_reg) + SUM_WIDTH'(j_reg) + SUM_WIDTH'(tau_reg);
  assign addr_a_next = SUM_WIDTH'(base_reg) + SUM_WIDTH'(j_reg) + SUM_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.start) state_next = ST_READ_A;
      ST_READ_A: state_next = ST_READ_B;
      ST_READ_B: state_next = (j_reg == J_LAST) ? ST_LAST : ST_READ_A;
      ST_LAST:   state_next = ST_EMIT;
      ST_EMIT:   if (bus.out_ready) state_next = last_tau ? ST_IDLE : ST_READ_A;
      default:   state_next = ST_IDLE;
    endcase
  end

  // The address register is loaded on entry to the state that presents it, so the
  // synchronous buffer returns sample_a in READ_B and sample_b in the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_reg     <= '0;
      tau_min_reg  <= '0;
      tau_max_reg  <= '0;
      tau_reg      <= '0;
      j_reg        <= '0;
      acc_reg      <= '0;
      sample_a_reg <= '0;
      address_reg  <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= handshake && last_tau;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            base_reg    <= bus.base_address;
            tau_min_reg <= bus.tau_min;
            tau_max_reg <= bus.tau_max;
            tau_reg     <= bus.tau_min;
            j_reg       <= '0;
            acc_reg     <= '0;
            address_reg <= bus.base_address;
          end
        end
        ST_READ_A: begin
          address_reg <= addr_b[ADDRESS_WIDTH-1:0];
          if (j_reg != '0) acc_reg <= acc_reg + ACC_WIDTH'(sq);
        end
        ST_READ_B: begin
          sample_a_reg <= bus.data_in;
          if (j_reg != J_LAST) begin
            j_reg       <= j_reg + WINDOW_SIZE_BITS'(1);
            address_reg <= addr_a_next[ADDRESS_WIDTH-1:0];
          end
        end
        ST_LAST: acc_reg <= acc_reg + ACC_WIDTH'(sq);
        ST_EMIT: begin
          if (bus.out_ready && !last_tau) begin
            tau_reg     <= tau_reg + TAU_WIDTH'(1);
            j_reg       <= '0;
            acc_reg     <= '0;
            address_reg <= base_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.address   = address_reg;
  assign bus.mem_oe    = (state_reg == ST_READ_A) || (state_reg == ST_READ_B);
  assign bus.out_valid = (state_reg == ST_EMIT);
  assign bus.out_tau   = tau_reg;
  assign bus.out_diff  = acc_reg;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_diff_sweep_engine.sv
// Bench for diff_sweep_engine with a 4-sample window and a 16-entry circular buffer;
// expected results come from a direct summation over the buffer contents.
module tb_diff_sweep_engine;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int WSB   = 2;
  localparam int TW    = 9;
  localparam int W     = 1 << WSB;
  localparam int DEPTH = 1 << AW;
  localparam int ACC   = 2 * DW + WSB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  diff_sweep_engine_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
                         .WINDOW_SIZE_BITS(WSB), .TAU_WIDTH(TW)) bus ();

  diff_sweep_engine #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
                      .WINDOW_SIZE_BITS(WSB), .TAU_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic signed [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.mem_oe) bus.data_in <= mem[bus.address];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          pat;
    logic [AW-1:0] b;
    logic [TW-1:0] tmin;
    logic [TW-1:0] tmax;
    longint      exp_diff;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int n = 0; n < DEPTH; n++) begin
      case (pat)
        0:       mem[n] = 16'sd100;
        1:       mem[n] = DW'(n);
        2:       mem[n] = (n % 2 == 0) ? -16'sd32768 : 16'sd32767;
        default: mem[n] = DW'($urandom);
      endcase
    end
  endtask

  function automatic longint model_d(input int b, input int t);
    longint s = 0;
    for (int j = 0; j < W; j++) begin
      longint d;
      d = longint'(mem[(b + j) % DEPTH]) - longint'(mem[(b + j + t) % DEPTH]);
      s += d * d;
    end
    return s;
  endfunction

  task automatic run_sweep(input logic [AW-1:0] b, input logic [TW-1:0] tmin,
                           input logic [TW-1:0] tmax, input bit rnd_ready,
                           input bit use_exp, input longint exp_diff);
    int n, k, c, early;
    bit seen, r;
    logic [TW-1:0] et;
    longint ed;
    n = (tmax < tmin) ? 1 : int'(tmax) - int'(tmin) + 1;
    @(negedge clk);
    bus.start = 1'b1; bus.base_address = b; bus.tau_min = tmin; bus.tau_max = tmax;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.base_address = ~b; bus.tau_min = ~tmin; bus.tau_max = ~tmax;
    check("busy_after_start", bus.busy, 1);
    k = 0; c = 0; seen = 0; early = 0;
    while (k < n && c < 4000) begin
      r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.done) early++;
      if (bus.out_valid) begin
        et = tmin + TW'(k);
        ed = use_exp ? exp_diff : model_d(int'(b), int'(et));
        if (!seen) begin
          check("out_tau", bus.out_tau, et);
          check("out_diff", bus.out_diff, ed);
          if (k == 0 && !rnd_ready) check("latency", c, 2 * W + 1);
          $display("result base=%0d tau=%0d diff=%0d cycle=%0d", b, bus.out_tau, bus.out_diff, c);
          seen = 1;
        end else begin
          check("hold_stable", {bus.out_tau, bus.out_diff}, {et, ed[ACC-1:0]});
        end
        if (r) begin k++; seen = 0; end
      end
      bus.out_ready = r;
      @(negedge clk);
      c++;
    end
    if (k < n) check("sweep_timeout", k, n);
    bus.out_ready = 1'b0;
    check("no_early_done", early, 0);
    check("done_pulse", bus.done, 1);
    @(negedge clk);
    check("done_clear_idle", {bus.done, bus.busy}, 0);
  endtask

  vec_t vecs [5];

  initial begin
    int cnt;
    logic [TW-1:0] tmin, tmax;
    vecs[0] = '{0, 4'd5,  9'd0, 9'd3, 64'd0};
    vecs[1] = '{1, 4'd0,  9'd3, 9'd3, 64'd36};
    vecs[2] = '{1, 4'd14, 9'd1, 9'd1, 64'd228};
    vecs[3] = '{2, 4'd0,  9'd1, 9'd1, 64'd17179344900};
    vecs[4] = '{1, 4'd0,  9'd3, 9'd1, 64'd36};

    bus.start = 1'b0; bus.base_address = '0; bus.tau_min = '0; bus.tau_max = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {bus.address, bus.mem_oe, bus.out_valid, bus.busy, bus.done,
                          bus.out_tau, bus.out_diff}, 0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      fill(vecs[i].pat);
      run_sweep(vecs[i].b, vecs[i].tmin, vecs[i].tmax, 1'b0, 1'b1, vecs[i].exp_diff);
    end

    // Backpressure: result must hold with no buffer reads until accepted
    fill(1);
    @(negedge clk);
    bus.start = 1'b1; bus.base_address = 4'd0; bus.tau_min = 9'd3; bus.tau_max = 9'd3;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 50) begin @(negedge clk); cnt++; end
    check("bp_valid_seen", bus.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {bus.out_valid, bus.out_tau, bus.out_diff, bus.mem_oe},
            {1'b1, 9'd3, 34'd36, 1'b0});
      @(negedge clk);
    end
    $display("backpressure held 10 cycles tau=%0d diff=%0d", bus.out_tau, bus.out_diff);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_done", bus.done, 1);
    bus.out_ready = 1'b0;
    @(negedge clk);

    // Reset during READ_B of the second lag
    @(negedge clk);
    bus.start = 1'b1; bus.base_address = 4'd0; bus.tau_min = 9'd1; bus.tau_max = 9'd3;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 50) begin @(negedge clk); cnt++; end
    check("rst_first_valid", {bus.out_valid, bus.out_tau}, {1'b1, 9'd1});
    @(negedge clk);
    check("rst_second_read_a", {bus.mem_oe, bus.busy}, 2'b11);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_outputs_zero", {bus.address, bus.mem_oe, bus.out_valid, bus.busy, bus.done,
                               bus.out_tau, bus.out_diff}, 0);
    $display("reset asserted mid-sweep");
    bus.out_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) cnt++;
    end
    check("rst_no_done", cnt, 0);
    reset = 1'b1;
    run_sweep(4'd0, 9'd1, 9'd3, 1'b0, 1'b0, 0);

    // Randomized buffers, ranges and backpressure
    for (int it = 0; it < 8; it++) begin
      fill(3);
      tmin = TW'($urandom_range(0, 40));
      if ($urandom_range(0, 4) == 0 && tmin > 0) tmax = tmin - 9'd1;
      else tmax = tmin + TW'($urandom_range(0, 3));
      run_sweep(AW'($urandom), tmin, tmax, 1'b1, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/diff_sweep_engine.md
Name: diff_sweep_engine

Overview:
Parametrised successor to the single-tau difference block for YIN pitch detection. Computes d(tau) = sum_{j=0}^{W-1} (x[base+j] - x[base+j+tau])^2 for every tau in [tau_min, tau_max] in one run. It reads the sample buffer through its single synchronous read port, wrapping addresses circularly. Results stream out on a valid/ready interface to the downstream CMNDF/threshold stage.

Parameters:
DATA_WIDTH, 16, sample width; signed two's complement
ADDRESS_WIDTH, 10, buffer address width; addresses wrap mod 2^ADDRESS_WIDTH
WINDOW_SIZE_BITS, 8, log2 of the window length; W = 2^WINDOW_SIZE_BITS
TAU_WIDTH, 9, width of the tau fields
ACC_WIDTH, 2*DATA_WIDTH+WINDOW_SIZE_BITS, accumulator/result width; derived, not overridden

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
base_address  in  ADDRESS_WIDTH  first sample of the window; latched at start
tau_min  in  TAU_WIDTH  first lag; latched at start
tau_max  in  TAU_WIDTH  last lag; latched at start
address  out  ADDRESS_WIDTH  buffer read address
mem_oe  out  1  buffer output enable; high in READ_A and READ_B
data_in  in  DATA_WIDTH  buffer read data; valid 1 cycle after address
out_valid  out  1  result available
out_ready  in  1  downstream accepts the result
out_tau  out  TAU_WIDTH  lag for the current result
out_diff  out  ACC_WIDTH  d(out_tau), unsigned
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the last result handshake

Behaviour:
- Reset while reset=0 (async). State goes to IDLE. address, out_tau, out_diff, accumulator, j and tau go to 0. out_valid, busy, done and mem_oe go to 0.
- IDLE: start=1 latches the inputs, sets tau=tau_min, j=0, clears acc and goes to READ_A. If tau_max < tau_min, only tau_min is computed.
- READ_A: address = base+j (wrapping); go to READ_B.
- READ_B: address = base+j+tau (wrapping); register the arriving sample_a = data_in.
  - If j < W-1: j++ and go to READ_A.
  - Else: go to LAST.
- Accumulate: in each READ_A with j>=1, and in LAST, data_in holds sample_b. Then acc += (sample_a - sample_b)^2.
- Width rules for accumulate: difference is DATA_WIDTH+1 signed; square is 2*DATA_WIDTH unsigned, exact; ACC_WIDTH cannot overflow.
- LAST: final accumulate, then go to EMIT.
- EMIT: out_valid=1. out_tau and out_diff are stable while out_ready=0.
- On the handshake (out_valid & out_ready):
  - If tau == tau_max, or tau_max < tau_min: pulse done the next cycle and go to IDLE.
  - Else: tau++, j=0, acc=0, go to READ_A.
- Latency: start sampled at edge E gives out_valid high after edge E+2W+1. With out_ready tied high, the result period is 2W+2 cycles per tau.
- tau=0 gives d=0.
- busy=1 in every state except IDLE. start while busy is ignored.
- Address arithmetic is ADDRESS_WIDTH bits, modulo; tau is zero-extended.
- Reset asserted mid-sweep aborts immediately with no done pulse. The next start restarts cleanly.

Decomposition:
- constants.vh holds DATA_WIDTH_BITS, BUFFER_SIZE_BITS, WINDOW_SIZE_BITS, the TAU_WIDTH default and state encodings (IDLE, READ_A, READ_B, LAST, EMIT).
- One combinational sub-module, sq_diff_unit (a, b -> (a-b)^2, 2*DATA_WIDTH bits unsigned), reused by later stages.

Test Plan:
- W=4, buffer constant 100, tau 0..3 -> four results, all out_diff=0; done pulses once after the 4th handshake.
- W=4, x[n]=n, base=0, tau_min=tau_max=3 -> single result out_diff=36 (4*3^2); out_valid first high 9 edges after start.
- W=4, ADDRESS_WIDTH=4, x[n]=n, base=14, tau=1 -> addresses wrap 14,15,0,1,2; the differences include 15-0 and 1-2. Expected out_diff = 1+225+1+1 = 228.
- W=4, alternating -32768/32767, tau=1 -> out_diff = 4*65535^2 = 17179344900, exact with no overflow.
- out_ready held 0 for 10 cycles in EMIT -> out_valid, out_tau and out_diff stay constant; no extra memory reads; resumes on ready.
- reset pulled low during READ_B of the 2nd tau -> all outputs 0 at once and no done pulse; a new start yields correct results from tau_min.
